// File: rtl/src_bus_arbiter.sv
// src_bus_arbiter: four-way round-robin owner of the 16-bit source bus.
// Drives the one-hot grant and the 2-bit select of the 4:1 source mux.
// Optional feature macro: SRC_ARB_LOCK_EN adds the LOCK input, which lets
// the current holder stay past MAX_HOLD while it keeps LOCK high.
module src_bus_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [3:0]       REQ,
`ifdef SRC_ARB_LOCK_EN
   input  logic             LOCK,
`endif
   output logic [3:0]       GNT,
   output logic [1:0]       SRC_SELECTION,
   output logic             BUS_BUSY,
   output logic [CNT_W-1:0] HOLD_CNT
);

   localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

   logic [3:0]       gnt_q,  gnt_d;
   logic [1:0]       sel_q,  sel_d;
   logic [1:0]       last_q, last_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic             lock_w;
   logic [3:0]       holder_oh;
   logic [3:0]       others;
   logic [2:0]       pick_idle;
   logic [2:0]       pick_next;

`ifdef SRC_ARB_LOCK_EN
   assign lock_w = LOCK;
`else
   assign lock_w = 1'b0;
`endif

   // Round-robin search starting at 'start', wrapping mod 4.
   // Returns {found, index}; the lowest offset from 'start' wins.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Holder masking and both candidate picks; the holder is excluded from handover picks.
   always_comb begin
      holder_oh = 4'b0001 << sel_q;
      others    = REQ & ~holder_oh;
      pick_idle = rr_pick(REQ, last_q + 2'd1);
      pick_next = rr_pick(others, sel_q + 2'd1);
   end

   // Next-state logic: grant from idle, release/handover, forced release, or keep.
   always_comb begin
      gnt_d  = gnt_q;
      sel_d  = sel_q;
      last_d = last_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (gnt_q == 4'b0000) begin
         if (pick_idle[2]) begin
            gnt_d  = 4'b0001 << pick_idle[1:0];
            sel_d  = pick_idle[1:0];
            last_d = pick_idle[1:0];
            busy_d = 1'b1;
            cnt_d  = CNT_W'(1);
         end
      end else if (!REQ[sel_q] ||
                   ((cnt_q >= MAX_HOLD_C) && (others != 4'b0000) && !lock_w)) begin
         if (pick_next[2]) begin
            gnt_d  = 4'b0001 << pick_next[1:0];
            sel_d  = pick_next[1:0];
            last_d = pick_next[1:0];
            busy_d = 1'b1;
            cnt_d  = CNT_W'(1);
         end else begin
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous active-low reset; A wins first after reset.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         gnt_q  <= 4'b0000;
         sel_q  <= 2'd0;
         last_q <= 2'd3;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         gnt_q  <= gnt_d;
         sel_q  <= sel_d;
         last_q <= last_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign GNT           = gnt_q;
   assign SRC_SELECTION = sel_q;
   assign BUS_BUSY      = busy_q;
   assign HOLD_CNT      = cnt_q;

endmodule

// File: tb/tb_src_bus_arbiter.sv
// Directed bench for src_bus_arbiter (MAX_HOLD=8, CNT_W=8).
// Define SRC_ARB_LOCK_EN for both files to exercise the LOCK input.
module tb_src_bus_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [3:0] REQ;
   logic       LOCK;
   logic [3:0] GNT;
   logic [1:0] SRC_SELECTION;
   logic       BUS_BUSY;
   logic [7:0] HOLD_CNT;

   int checks = 0;
   int errors = 0;

   src_bus_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .REQ           (REQ),
`ifdef SRC_ARB_LOCK_EN
      .LOCK          (LOCK),
`endif
      .GNT           (GNT),
      .SRC_SELECTION (SRC_SELECTION),
      .BUS_BUSY      (BUS_BUSY),
      .HOLD_CNT      (HOLD_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                          input logic b, input logic [7:0] c);
      chk({tag, ".gnt"},  32'(GNT), 32'(g));
      chk({tag, ".sel"},  32'(SRC_SELECTION), 32'(s));
      chk({tag, ".busy"}, 32'(BUS_BUSY), 32'(b));
      chk({tag, ".cnt"},  32'(HOLD_CNT), 32'(c));
   endtask

   initial begin
      int hold;
      RESET_N = 1'b0;
      REQ     = 4'b1111;
      LOCK    = 1'b0;

      // Reset held 3 cycles with all requests high
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("reset", 4'b0000, 2'd0, 1'b0, 8'd0);
      end
      RESET_N = 1'b1;
      tick();
      chk_all("first_after_reset", 4'b0001, 2'd0, 1'b1, 8'd1);
      REQ = 4'b0000;
      tick();
      chk_all("idle_after_a", 4'b0000, 2'd0, 1'b0, 8'd0);

      // C alone for 5 cycles, then drop
      REQ = 4'b0100;
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk_all("c_hold", 4'b0100, 2'd2, 1'b1, 8'(c));
      end
      REQ = 4'b0000;
      tick();
      chk_all("c_release_idle", 4'b0000, 2'd2, 1'b0, 8'd0);

      // All request: LAST=C so order is D,A,B,C, 8 cycles each, no gaps
      REQ = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         hold = (3 + k) % 4;
         for (int c = 1; c <= 8; c++) begin
            tick();
            chk_all("rotate", 4'b0001 << hold, 2'(hold), 1'b1, 8'(c));
         end
      end
      tick();
      chk_all("rotate_wrap_d", 4'b1000, 2'd3, 1'b1, 8'd1);
      REQ = 4'b0000;
      tick();
      chk_all("rotate_idle", 4'b0000, 2'd3, 1'b0, 8'd0);

      // A holding, B joins at cycle 3, A drops after cycle 5
      REQ = 4'b0001;
      tick(); chk_all("ab_a1", 4'b0001, 2'd0, 1'b1, 8'd1);
      tick(); chk_all("ab_a2", 4'b0001, 2'd0, 1'b1, 8'd2);
      REQ = 4'b0011;
      tick(); chk_all("ab_a3", 4'b0001, 2'd0, 1'b1, 8'd3);
      tick(); chk_all("ab_a4", 4'b0001, 2'd0, 1'b1, 8'd4);
      tick(); chk_all("ab_a5", 4'b0001, 2'd0, 1'b1, 8'd5);
      REQ = 4'b0010;
      tick(); chk_all("ab_handover", 4'b0010, 2'd1, 1'b1, 8'd1);
      REQ = 4'b0000;
      tick(); chk_all("ab_idle", 4'b0000, 2'd1, 1'b0, 8'd0);

      // D alone for 300 cycles: counter saturates at 255
      REQ = 4'b1000;
      for (int c = 1; c <= 300; c++) begin
         tick();
         chk_all("d_sat", 4'b1000, 2'd3, 1'b1, (c > 255) ? 8'd255 : 8'(c));
      end
      REQ = 4'b1010;
      tick();
      chk_all("d_to_b", 4'b0010, 2'd1, 1'b1, 8'd1);
      REQ = 4'b0000;
      tick();
      chk_all("d_to_b_idle", 4'b0000, 2'd1, 1'b0, 8'd0);

`ifdef SRC_ARB_LOCK_EN
      // A locks the bus past MAX_HOLD while C waits; dropping LOCK hands over
      REQ  = 4'b0001;
      LOCK = 1'b1;
      tick();
      chk_all("lock_a1", 4'b0001, 2'd0, 1'b1, 8'd1);
      REQ = 4'b0101;
      for (int c = 2; c <= 12; c++) begin
         tick();
         chk_all("lock_hold", 4'b0001, 2'd0, 1'b1, 8'(c));
      end
      LOCK = 1'b0;
      tick();
      chk_all("lock_to_c", 4'b0100, 2'd2, 1'b1, 8'd1);
      REQ = 4'b0000;
      tick();
      chk_all("lock_idle", 4'b0000, 2'd2, 1'b0, 8'd0);
`endif

      // Reset in the middle of an ownership overrides the grant
      REQ = 4'b0010;
      tick();
      chk("mid_pre.gnt", 32'(GNT), 32'h2);
      RESET_N = 1'b0;
      tick();
      chk_all("mid_reset", 4'b0000, 2'd0, 1'b0, 8'd0);
      RESET_N = 1'b1;
      REQ = 4'b0110;
      tick();
      chk_all("post_reset_pick", 4'b0010, 2'd1, 1'b1, 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
